yuv420_scan_ctrl: RTL

Frame scan-out sequencer for the decoder's display path. Fetches a planar YUV 4:2:0 frame from the byte-wide reconstructed-frame memory through one shared read port, and feeds the registered YUV→RGB converter (`yuv2rgb_core`, 1-cycle latency, no enable). Handles converter backpressure with a small output FIFO. Emits a raster-ordered 24-bit RGB pixel stream with valid/ready and frame/line markers.

---
 rtl/disp_pkg.sv | 46 ++++
 rtl/sync_fifo.sv | 56 +++++
 rtl/yuv420_scan_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// Shared types and sizing helpers for the display scan-out path.
// Plane sizes are derived from the frame geometry; the defaults describe a QCIF frame.
package disp_pkg;

  localparam int DEF_W  = 176;
  localparam int DEF_H  = 144;
  localparam int Y_SIZE = DEF_W * DEF_H;
  localparam int C_SIZE = Y_SIZE / 4;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CHK,
    S_RD_Y0,
    S_RD_Y1,
    S_RD_U,
    S_RD_V,
    S_CAP_V,
    S_CV0,
    S_CV1,
    S_DRAIN
  } scan_state_t;

  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } pix_tag_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    pix_tag_t   tag;
  } fifo_entry_t;

  localparam int ENTRY_W = $bits(fifo_entry_t);

  function automatic int y_size(input int w, input int h);
    return w * h;
  endfunction

  function automatic int c_size(input int w, input int h);
    return (w * h) / 4;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy count.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PW + 1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // NOTE: the storage array is deliberately not reset; only pointers and count
  // carry state, so stale entries are never visible and the array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW + 1)'(1);
        2'b01:   count <= count - (PW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/yuv420_scan_ctrl.sv
// Planar YUV 4:2:0 frame scan-out: fetches one pixel pair per pass through a shared
// byte read port, feeds the external 1-cycle converter and buffers RGB in a small FIFO.
module yuv420_scan_ctrl
  import disp_pkg::*;
#(
  parameter int W  = 176,
  parameter int H  = 144,
  parameter int AW = 17,
  parameter int FD = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] frame_base,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rd_data,
  output logic [7:0]    conv_y,
  output logic [7:0]    conv_u,
  output logic [7:0]    conv_v,
  input  logic [7:0]    conv_r,
  input  logic [7:0]    conv_g,
  input  logic [7:0]    conv_b,
  output logic          rgb_valid,
  input  logic          rgb_ready,
  output logic [23:0]   rgb_data,
  output logic          rgb_sof,
  output logic          rgb_eol,
  output logic          rgb_eof,
  output logic          busy,
  output logic          done
);

  localparam int XW = $clog2(W + 1);
  localparam int YW = $clog2(H + 1);
  localparam int CW = $clog2(FD) + 1;

  localparam logic [AW-1:0] Y_BYTES   = AW'(y_size(W, H));
  localparam logic [AW-1:0] C_BYTES   = AW'(c_size(W, H));
  localparam logic [AW-1:0] HALF_W    = AW'(W / 2);
  localparam logic [XW-1:0] LAST_COL  = XW'(W - 2);
  localparam logic [YW-1:0] LAST_ROW  = YW'(H - 1);
  localparam logic [CW:0]   ADMIT_MAX = (CW + 1)'(FD - 2);

  scan_state_t   state;
  logic [AW-1:0] y_ptr;
  logic [AW-1:0] c_row;
  logic [AW-1:0] c_col;
  logic [XW-1:0] col;
  logic [YW-1:0] row;
  logic [7:0]    y0_q;
  logic [7:0]    y1_q;
  logic [7:0]    u_q;

  // Two-stage valid/tag shadow of the converter: stage 1 aligns with conv_* inputs,
  // stage 2 with conv_r/g/b.
  logic          v1;
  logic          v2;
  pix_tag_t      t1;
  pix_tag_t      t2;

  logic [1:0]    inflight;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   occupancy;
  logic          fifo_empty;
  logic          pop;
  logic          last_pair;
  fifo_entry_t   push_entry;
  fifo_entry_t   pop_entry;

  assign inflight  = {1'b0, v1} + {1'b0, v2};
  assign occupancy = {1'b0, fifo_count} + {{(CW - 1){1'b0}}, inflight};
  assign last_pair = (col == LAST_COL) && (row == LAST_ROW);

  assign push_entry = '{r: conv_r, g: conv_g, b: conv_b, tag: t2};

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FD)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (v2),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (pop_entry),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Output fields are gated with valid so the unreset FIFO storage never leaks out.
  assign rgb_valid = !fifo_empty;
  assign pop       = rgb_valid && rgb_ready;
  assign rgb_data  = rgb_valid ? {pop_entry.r, pop_entry.g, pop_entry.b} : 24'd0;
  assign rgb_sof   = rgb_valid && pop_entry.tag.sof;
  assign rgb_eol   = rgb_valid && pop_entry.tag.eol;
  assign rgb_eof   = rgb_valid && pop_entry.tag.eof;
  assign done      = (state == S_DRAIN) && pop && pop_entry.tag.eof;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      conv_y    <= '0;
      conv_u    <= '0;
      conv_v    <= '0;
      y_ptr     <= '0;
      c_row     <= '0;
      c_col     <= '0;
      col       <= '0;
      row       <= '0;
      y0_q      <= '0;
      y1_q      <= '0;
      u_q       <= '0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      t1        <= '0;
      t2        <= '0;
    end else begin
      v1 <= 1'b0;
      v2 <= v1;
      t2 <= t1;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_CHK;
            busy  <= 1'b1;
            y_ptr <= frame_base;
            c_row <= frame_base + Y_BYTES;
            c_col <= '0;
            col   <= '0;
            row   <= '0;
          end
        end
        // Admit a pair only when both of its pushes are guaranteed a FIFO slot.
        S_CHK: begin
          if (occupancy <= ADMIT_MAX) begin
            state     <= S_RD_Y0;
            mem_rd_en <= 1'b1;
            mem_addr  <= y_ptr;
          end
        end
        S_RD_Y0: begin
          state    <= S_RD_Y1;
          mem_addr <= y_ptr + AW'(1);
        end
        S_RD_Y1: begin
          state    <= S_RD_U;
          y0_q     <= mem_rd_data;
          mem_addr <= c_row + c_col;
        end
        S_RD_U: begin
          state    <= S_RD_V;
          y1_q     <= mem_rd_data;
          mem_addr <= c_row + c_col + C_BYTES;
        end
        S_RD_V: begin
          state     <= S_CAP_V;
          u_q       <= mem_rd_data;
          mem_rd_en <= 1'b0;
        end
        S_CAP_V: begin
          state  <= S_CV0;
          conv_y <= y0_q;
          conv_u <= u_q;
          conv_v <= mem_rd_data;
          v1     <= 1'b1;
          t1     <= '{sof: (row == '0) && (col == '0), eol: 1'b0, eof: 1'b0};
        end
        S_CV0: begin
          state  <= S_CV1;
          conv_y <= y1_q;
          v1     <= 1'b1;
          t1     <= '{sof: 1'b0, eol: (col == LAST_COL), eof: last_pair};
        end
        S_CV1: begin
          state <= last_pair ? S_DRAIN : S_CHK;
          y_ptr <= y_ptr + AW'(2);
          if (col == LAST_COL) begin
            col   <= '0;
            c_col <= '0;
            row   <= row + YW'(1);
            // Even and odd rows share a chroma line; step it after the odd row.
            if (row[0]) c_row <= c_row + HALF_W;
          end else begin
            col   <= col + XW'(2);
            c_col <= c_col + AW'(1);
          end
        end
        S_DRAIN: begin
          if (done) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
